// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the fetch PC block: address type, reset/exception
// defaults and the RUN/PEND state encoding.
package pc_next_unit_pkg;

  typedef logic [31:0] addr_t;

  localparam addr_t DEF_RESET_PC   = 32'hBFC0_0000;
  localparam addr_t DEF_EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_unit_pc_target_sel.sv
// Combinational next-PC target formation and request priority mux.
// Optional exception redirect is compiled in with EXC_REDIRECT_EN.
module pc_target_sel
  import pc_next_unit_pkg::*;
#(
`ifdef EXC_REDIRECT_EN
  parameter addr_t EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
  input  logic [31:0] pc_f,
  input  logic        branch_taken_d,
  input  logic [31:0] sl2_offset_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        jump_d,
  input  logic [25:0] instr_index_d,
  input  logic        jr_d,
  input  logic [31:0] jr_addr_d,
`ifdef EXC_REDIRECT_EN
  input  logic        exc_req,
`endif
  output logic [31:0] target,
  output logic        req
);

  addr_t branch_target;
  addr_t jump_target;

  assign branch_target = pc_plus4_d + sl2_offset_d;
  assign jump_target   = {pc_plus4_d[31:28], instr_index_d, 2'b00};

  always_comb begin
    target = pc_f + 32'd4;
    req    = 1'b1;
`ifdef EXC_REDIRECT_EN
    if (exc_req)             target = EXC_VECTOR;
    else
`endif
    if (jr_d)                target = jr_addr_d;
    else if (jump_d)         target = jump_target;
    else if (branch_taken_d) target = branch_target;
    else                     req    = 1'b0;
  end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch PC register with stall-time redirect buffering (RUN/PEND FSM).
// Define EXC_REDIRECT_EN to add the exc_req port and exception vector redirect.
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter addr_t RESET_PC   = DEF_RESET_PC
`ifdef EXC_REDIRECT_EN
  ,
  parameter addr_t EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        branch_taken_d,
  input  logic [31:0] sl2_offset_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        jump_d,
  input  logic [25:0] instr_index_d,
  input  logic        jr_d,
  input  logic [31:0] jr_addr_d,
`ifdef EXC_REDIRECT_EN
  input  logic        exc_req,
`endif
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        redirect_f,
  output logic        adel_f,
  output logic        pending_f
);

  state_t state, state_next;
  addr_t  pc_next, pend_addr, pend_addr_next;
  logic   redirect_next;
  addr_t  target;
  logic   req;
  logic   exc_hit;

`ifdef EXC_REDIRECT_EN
  assign exc_hit = exc_req;

  pc_target_sel #(.EXC_VECTOR(EXC_VECTOR)) u_sel (
    .pc_f(pc_f), .branch_taken_d(branch_taken_d), .sl2_offset_d(sl2_offset_d),
    .pc_plus4_d(pc_plus4_d), .jump_d(jump_d), .instr_index_d(instr_index_d),
    .jr_d(jr_d), .jr_addr_d(jr_addr_d), .exc_req(exc_req),
    .target(target), .req(req)
  );
`else
  assign exc_hit = 1'b0;

  pc_target_sel u_sel (
    .pc_f(pc_f), .branch_taken_d(branch_taken_d), .sl2_offset_d(sl2_offset_d),
    .pc_plus4_d(pc_plus4_d), .jump_d(jump_d), .instr_index_d(instr_index_d),
    .jr_d(jr_d), .jr_addr_d(jr_addr_d),
    .target(target), .req(req)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc_f       <= RESET_PC;
      pend_addr  <= '0;
      redirect_f <= 1'b0;
    end else begin
      state      <= state_next;
      pc_f       <= pc_next;
      pend_addr  <= pend_addr_next;
      redirect_f <= redirect_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc_f;
    pend_addr_next = pend_addr;
    redirect_next  = 1'b0;
    unique case (state)
      RUN: begin
        if (!stall_f) begin
          pc_next       = target;
          redirect_next = req;
        end else if (req) begin
          pend_addr_next = target;
          state_next     = PEND;
        end
      end
      PEND: begin
        if (stall_f) begin
          if (req) pend_addr_next = target;
        end else begin
          // Only an exception may displace the buffered redirect on release.
          pc_next       = exc_hit ? target : pend_addr;
          redirect_next = 1'b1;
          state_next    = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign pc_plus4_f = pc_f + 32'd4;
  assign adel_f     = |pc_f[1:0];
  assign pending_f  = (state == PEND);

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed test-plan steps followed by
// randomized traffic checked against a behavioural fetch-PC model.
module tb_pc_next_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, branch_taken_d, jump_d, jr_d;
  logic [31:0] sl2_offset_d, pc_plus4_d, jr_addr_d;
  logic [25:0] instr_index_d;
  logic        exc_req;
  logic [31:0] pc_f, pc_plus4_f;
  logic        redirect_f, adel_f, pending_f;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: architectural PC, redirect flag and a buffer of
  // at most one waiting redirect address.
  logic [31:0] m_pc;
  logic        m_red;
  logic [31:0] m_pendq[$];

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .stall_f(stall_f),
    .branch_taken_d(branch_taken_d), .sl2_offset_d(sl2_offset_d),
    .pc_plus4_d(pc_plus4_d), .jump_d(jump_d), .instr_index_d(instr_index_d),
    .jr_d(jr_d), .jr_addr_d(jr_addr_d),
`ifdef EXC_REDIRECT_EN
    .exc_req(exc_req),
`endif
    .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .redirect_f(redirect_f),
    .adel_f(adel_f), .pending_f(pending_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_f"}, pc_f, m_pc);
    check({tag, ".pc_plus4_f"}, pc_plus4_f, m_pc + 32'd4);
    check({tag, ".redirect_f"}, {31'd0, redirect_f}, {31'd0, m_red});
    check({tag, ".adel_f"}, {31'd0, adel_f}, {31'd0, m_pc[1:0] != 2'b00});
    check({tag, ".pending_f"}, {31'd0, pending_f}, {31'd0, m_pendq.size() != 0});
    $display("%s: pc_f=%h redirect=%b adel=%b pending=%b", tag, pc_f, redirect_f, adel_f, pending_f);
  endtask

  task automatic model_reset();
    m_pc  = RST_PC;
    m_red = 1'b0;
    m_pendq.delete();
  endtask

  // One clock edge: model update from the spec rules, then compare.
  task automatic tick(input string tag);
    logic        have_req, exc;
    logic [31:0] tgt;
    exc = 1'b0;
`ifdef EXC_REDIRECT_EN
    exc = exc_req;
`endif
    have_req = exc | jr_d | jump_d | branch_taken_d;
    if (exc)                 tgt = EXC_PC;
    else if (jr_d)           tgt = jr_addr_d;
    else if (jump_d)         tgt = {pc_plus4_d[31:28], instr_index_d, 2'b00};
    else if (branch_taken_d) tgt = pc_plus4_d + sl2_offset_d;
    else                     tgt = m_pc + 32'd4;

    if (stall_f) begin
      m_red = 1'b0;
      if (have_req) begin
        m_pendq.delete();
        m_pendq.push_back(tgt);
      end
    end else if (m_pendq.size() != 0) begin
      m_pc  = exc ? EXC_PC : m_pendq.pop_front();
      m_pendq.delete();
      m_red = 1'b1;
    end else begin
      m_pc  = tgt;
      m_red = have_req;
    end

    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    stall_f = 0; branch_taken_d = 0; jump_d = 0; jr_d = 0; exc_req = 0;
    sl2_offset_d = '0; pc_plus4_d = '0; jr_addr_d = '0; instr_index_d = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch after reset.
    tick("seq1"); tick("seq2"); tick("seq3");
    check("seq3.value", pc_f, 32'hBFC0_000C);

    // Taken branch, backwards offset.
    branch_taken_d = 1; pc_plus4_d = 32'h0040_0010; sl2_offset_d = 32'hFFFF_FFF0;
    tick("branch");
    check("branch.value", pc_f, 32'h0040_0000);
    idle_inputs();
    tick("branch_after");

    // Jump beats branch.
    jump_d = 1; branch_taken_d = 1; pc_plus4_d = 32'h9000_0004;
    instr_index_d = 26'h000_0010; sl2_offset_d = 32'h0000_0100;
    tick("jump_prio");
    check("jump_prio.value", pc_f, 32'h9000_0040);
    idle_inputs();

    // jr during a three-cycle stall, misaligned target.
    stall_f = 1; jr_d = 1; jr_addr_d = 32'h0040_0002;
    tick("jr_stall1");
    jr_d = 0;
    tick("jr_stall2"); tick("jr_stall3");
    stall_f = 0;
    tick("jr_release");
    check("jr_release.value", pc_f, 32'h0040_0002);
    tick("jr_next");
    check("jr_next.value", pc_f, 32'h0040_0006);

    // Newest stalled request wins; request on release is ignored.
    stall_f = 1; branch_taken_d = 1; pc_plus4_d = 32'h0000_1000; sl2_offset_d = 32'h0000_0020;
    tick("newest1");
    branch_taken_d = 0; jump_d = 1; instr_index_d = 26'h012_3456;
    tick("newest2");
    stall_f = 0; jump_d = 0; jr_d = 1; jr_addr_d = 32'h1234_5678;
    tick("newest_release");
    idle_inputs();

    // Wrap at the top of the address space.
    jr_d = 1; jr_addr_d = 32'hFFFF_FFFC;
    tick("wrap_set");
    jr_d = 0;
    tick("wrap");
    check("wrap.value", pc_f, 32'h0000_0000);

    // Asynchronous reset in the middle of a pending redirect.
    stall_f = 1; branch_taken_d = 1; pc_plus4_d = 32'h0000_2000; sl2_offset_d = 32'h4;
    tick("pend_before_rst");
    idle_inputs();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    tick("after_rst");

`ifdef EXC_REDIRECT_EN
    // Exception overrides a buffered jr during stall.
    stall_f = 1; jr_d = 1; jr_addr_d = 32'h0040_0100;
    tick("exc_pend1");
    jr_d = 0; exc_req = 1;
    tick("exc_pend2");
    exc_req = 0; stall_f = 0;
    tick("exc_release");
    check("exc_release.value", pc_f, EXC_PC);
    // Exception arriving on the release cycle replaces the buffered target.
    stall_f = 1; jump_d = 1; pc_plus4_d = 32'h1000_0000; instr_index_d = 26'h5;
    tick("exc_rel_pend");
    jump_d = 0; stall_f = 0; exc_req = 1;
    tick("exc_on_release");
    idle_inputs();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stall_f        = ($urandom_range(0, 9) < 3);
      branch_taken_d = ($urandom_range(0, 9) < 2);
      jump_d         = ($urandom_range(0, 9) < 1);
      jr_d           = ($urandom_range(0, 9) < 1);
`ifdef EXC_REDIRECT_EN
      exc_req        = ($urandom_range(0, 19) < 1);
`endif
      sl2_offset_d   = {{14{$urandom_range(0, 1) == 1}}, 16'($urandom()), 2'b00};
      pc_plus4_d     = $urandom();
      instr_index_d  = 26'($urandom());
      jr_addr_d      = $urandom();
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Fetch-stage program-counter block for the pipelined MIPS core. It consumes the word-aligned branch offset produced by the shift-left-2 branch-offset unit and the decode-stage redirect requests, and forms the branch, jump and jump-register targets. It holds the architectural fetch PC in a register. Redirects that arrive during a fetch stall are buffered and applied when the stall releases.

## Interface
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset
- EXC_VECTOR, 32'hBFC0_0380, exception entry address (used only with EXC_REDIRECT_EN)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_f  in  1  hold PC; no update this edge
- branch_taken_d  in  1  decode-stage branch resolved taken
- sl2_offset_d  in  32  sign-extended offset, already shifted left 2
- pc_plus4_d  in  32  PC+4 of the decode-stage instruction
- jump_d  in  1  j/jal in decode
- instr_index_d  in  26  jump instr_index field
- jr_d  in  1  jr/jalr in decode
- jr_addr_d  in  32  forwarded rs value
- exc_req  in  1  exception redirect (EXC_REDIRECT_EN only)
- pc_f  out  32  current fetch PC
- pc_plus4_f  out  32  pc_f + 4, combinational
- redirect_f  out  1  one-cycle pulse: pc_f was loaded from a non-sequential target on the last edge
- adel_f  out  1  pc_f[1:0] != 0 (jr to misaligned address)
- pending_f  out  1  a buffered redirect is waiting

## Operation
- Targets, all modulo 2^32:
  - branch = pc_plus4_d + sl2_offset_d
  - jump = {pc_plus4_d[31:28], instr_index_d, 2'b00}
  - jr = jr_addr_d, unmodified
- Request priority: exc_req > jr_d > jump_d > branch_taken_d > sequential (pc_f + 4). Simultaneous requests select the highest-priority target only.
- State machine, two states:
  - RUN:
    - stall_f=0: pc_f <= selected target. redirect_f=1 if any request was active.
    - stall_f=1 with a request: latch the target into pend_addr and go to PEND. pc_f is held.
    - stall_f=1 without a request: hold everything.
  - PEND:
    - stall_f=1: hold. A new request overwrites pend_addr (newest wins). exc_req always overwrites.
    - stall_f=0: pc_f <= pend_addr, redirect_f=1, return to RUN. Requests present in the same cycle are ignored, except exc_req, which takes pend's place.
- adel_f is derived from pc_f. The block does not trap; it only flags. A misaligned PC still increments by 4.
- pending_f = (state == PEND).

## Timing
- Reset (async, rst high): pc_f=RESET_PC, state=RUN, pend_addr=0, redirect_f=0. adel_f=0 and pending_f=0 follow from these.
- Redirect latency: a request at edge N with stall_f=0 gives pc_f=target after edge N.
- A stalled redirect is applied on the first edge with stall_f=0.
- redirect_f is registered and high for exactly one cycle per applied redirect.
- Reset asserted mid-PEND discards pend_addr.
- pc_f=32'hFFFF_FFFC sequential wraps to 32'h0000_0000.

## Configuration
- EXC_REDIRECT_EN defined: exc_req port exists and redirects to EXC_VECTOR at top priority, including out of PEND and during stall (it is buffered like the others).
- Not defined: no exc_req port; the priority chain starts at jr_d; EXC_VECTOR is unused.

## Structure
- Shared package holds RESET_PC and EXC_VECTOR defaults, the RUN/PEND state encoding, and the 32-bit address type.
- One sub-module, pc_target_sel: the combinational target formation and priority mux. Outputs are the target and a request-valid bit.
- The top level holds the PC register, pend_addr and the FSM.

## Test plan
- Reset release, 3 unstalled cycles -> pc_f = BFC00000, BFC00004, BFC00008, BFC0000C. redirect_f=0 throughout.
- branch_taken_d with pc_plus4_d=00400010, sl2_offset_d=FFFFFFF0 -> next pc_f=00400000, redirect_f pulse 1 cycle.
- jump_d with pc_plus4_d=90000004, instr_index_d=0000010, and branch_taken_d=1 simultaneously -> pc_f=90000040 (jump wins).
- jr_d with jr_addr_d=00400002 while stall_f=1 for 3 cycles -> pending_f=1, pc_f held. On release pc_f=00400002, adel_f=1, then 00400006.
- Sequential from FFFFFFFC -> pc_f=00000000.
- With EXC_REDIRECT_EN: exc_req during PEND plus stall -> on release pc_f=BFC00380. rst pulse mid-PEND -> pc_f=BFC00000, pending_f=0.
